// File: rtl/cache_pkg.sv
// Shared types and helpers for the trace request sequencer.
//   trace_op_e   - trace opcodes understood by the split L1 front end
//   seq_state_e  - sequencer FSM states
//   ADDR_W_DEF   - default request address width
//   is_legal_op  - opcode legality check
//   hex_digit    - ASCII hex character decode, returns {valid, value}
package cache_pkg;

  localparam int ADDR_W_DEF = 32;

  typedef enum logic [3:0] {
    OP_RD_D    = 4'd0,
    OP_WR_D    = 4'd1,
    OP_FETCH_I = 4'd2,
    OP_INVAL   = 4'd3,
    OP_SNOOP   = 4'd4,
    OP_CLEAR   = 4'd8,
    OP_PRINT   = 4'd9
  } trace_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_DONE
  } seq_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_RD_D, OP_WR_D, OP_FETCH_I, OP_INVAL,
      OP_SNOOP, OP_CLEAR, OP_PRINT: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] hex_digit(input logic [7:0] ch);
    if (ch >= "0" && ch <= "9") return {1'b1, 4'(ch - "0")};
    if (ch >= "a" && ch <= "f") return {1'b1, 4'(ch - "a" + 8'd10)};
    if (ch >= "A" && ch <= "F") return {1'b1, 4'(ch - "A" + 8'd10)};
    return 5'd0;
  endfunction

endpackage

// File: rtl/trace_line_parser.sv
// Parses one trace line of the form "<decimal op> <hex address>".
// Character i of the line sits in line_data[8*i +: 8]; the line ends at
// the first NUL or newline. Spaces, tabs and CR are whitespace.
//   line_data - current unread line        line_eof - no line left
//   op/addr   - parsed fields              ok       - well formed, legal op
//   blank     - whitespace-only line       eof      - end of trace
//   trunc     - address had set bits above ADDR_W (addr keeps the low bits)
module trace_line_parser
  import cache_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_LINE = 128
) (
  input  logic [MAX_LINE*8-1:0] line_data,
  input  logic                  line_eof,
  output logic [3:0]            op,
  output logic [ADDR_W-1:0]     addr,
  output logic                  ok,
  output logic                  blank,
  output logic                  eof,
  output logic                  trunc
);

  typedef enum logic [2:0] {PH_LEAD, PH_OP, PH_GAP, PH_ADDR, PH_TAIL} phase_e;

  phase_e              phase;
  logic [7:0]          ch;
  logic [7:0]          op_acc;
  logic [4:0]          hx;
  logic [ADDR_W+3:0]   addr_ext;
  logic [ADDR_W-1:0]   addr_acc;
  logic                ended, bad, nonblank, trunc_acc, is_ws, is_dec;

  // Character scanner. op_acc stops growing once above 15, which is
  // already illegal, so it never overflows its 8 bits.
  always_comb begin
    phase     = PH_LEAD;
    ch        = 8'd0;
    op_acc    = 8'd0;
    hx        = 5'd0;
    addr_ext  = '0;
    addr_acc  = '0;
    ended     = 1'b0;
    bad       = 1'b0;
    nonblank  = 1'b0;
    trunc_acc = 1'b0;
    is_ws     = 1'b0;
    is_dec    = 1'b0;
    for (int i = 0; i < MAX_LINE; i++) begin
      ch       = line_data[8*i +: 8];
      hx       = hex_digit(ch);
      is_ws    = (ch == 8'h20) || (ch == 8'h09) || (ch == 8'h0D);
      is_dec   = hx[4] && (ch <= "9");
      addr_ext = {addr_acc, hx[3:0]};
      if (!ended) begin
        if (ch == 8'h00 || ch == 8'h0A) begin
          ended = 1'b1;
        end else begin
          if (!is_ws) nonblank = 1'b1;
          case (phase)
            PH_LEAD, PH_OP: begin
              if (is_dec) begin
                if (op_acc <= 8'd15) op_acc = (op_acc * 8'd10) + {4'd0, hx[3:0]};
                phase = PH_OP;
              end else if (is_ws && phase == PH_OP) begin
                phase = PH_GAP;
              end else if (!is_ws) begin
                bad = 1'b1;
              end
            end
            PH_GAP, PH_ADDR: begin
              if (hx[4]) begin
                if (addr_ext[ADDR_W+3:ADDR_W] != 4'd0) trunc_acc = 1'b1;
                addr_acc = addr_ext[ADDR_W-1:0];
                phase    = PH_ADDR;
              end else if (is_ws && phase == PH_ADDR) begin
                phase = PH_TAIL;
              end else if (!is_ws) begin
                bad = 1'b1;
              end
            end
            PH_TAIL:  if (!is_ws) bad = 1'b1;
            default:  bad = 1'b1;
          endcase
        end
      end
    end
  end

  assign op    = op_acc[3:0];
  assign addr  = addr_acc;
  assign blank = !nonblank;
  assign eof   = line_eof;
  assign trunc = trunc_acc;
  assign ok    = !bad && nonblank && (phase == PH_ADDR || phase == PH_TAIL) &&
                 (op_acc <= 8'd15) && is_legal_op(op_acc[3:0]);

endmodule

// File: rtl/trace_request_sequencer.sv
// Walks a trace one line per cycle and issues each parsed line as a cache
// request on a valid/ready handshake.
// The trace source shows the current unread line on line_data/line_eof and
// advances on every clock where line_rd is high, so its position survives
// a sequencer reset and a restart resumes at the next unread line.
//   clk, rst_n          - clock, asynchronous active-low reset
//   file, mode, start   - handle (0 = open failed), run mode, start pulse
//   req_*               - request handshake to the I/D dispatcher
//   busy, done          - FETCH/ISSUE activity, absorbing end state
//   line_count          - lines consumed (wraps)
//   err_count           - skipped or truncated lines (saturates)
//   open_err            - start seen with file == 0
//   line_rd, line_data, line_eof - trace line source
//   log_req             - handshake to be displayed (mode >= VERBOSE_MODE)
//   log_summary         - pulse on entry to DONE, time to display totals
module trace_request_sequencer
  import cache_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int MAX_LINE     = 128,
  parameter int VERBOSE_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           file,
  input  logic [31:0]           mode,
  input  logic                  start,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [3:0]            req_op,
  output logic [ADDR_W-1:0]     req_addr,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           line_count,
  output logic [15:0]           err_count,
  output logic                  open_err,
  output logic                  line_rd,
  input  logic [MAX_LINE*8-1:0] line_data,
  input  logic                  line_eof,
  output logic                  log_req,
  output logic                  log_summary
);

  seq_state_e          state_q, state_d;
  logic                req_valid_q, req_valid_d;
  logic [3:0]          req_op_q, req_op_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [31:0]         line_count_q, line_count_d;
  logic [15:0]         err_count_q, err_count_d;
  logic                open_err_q, open_err_d;

  logic [3:0]          p_op;
  logic [ADDR_W-1:0]   p_addr;
  logic                p_ok, p_blank, p_eof, p_trunc;
  logic [15:0]         err_inc;

  trace_line_parser #(
    .ADDR_W   (ADDR_W),
    .MAX_LINE (MAX_LINE)
  ) u_parser (
    .line_data (line_data),
    .line_eof  (line_eof),
    .op        (p_op),
    .addr      (p_addr),
    .ok        (p_ok),
    .blank     (p_blank),
    .eof       (p_eof),
    .trunc     (p_trunc)
  );

  assign err_inc = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;

  // Next-state logic. A truncated address still issues but is also counted
  // as an error line.
  always_comb begin
    state_d      = state_q;
    req_valid_d  = req_valid_q;
    req_op_d     = req_op_q;
    req_addr_d   = req_addr_q;
    line_count_d = line_count_q;
    err_count_d  = err_count_q;
    open_err_d   = open_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (file == 32'd0) begin
            open_err_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (p_eof) begin
          state_d = ST_DONE;
        end else begin
          line_count_d = line_count_q + 32'd1;
          if (p_blank) begin
            state_d = ST_FETCH;
          end else if (!p_ok) begin
            err_count_d = err_inc;
          end else begin
            req_op_d    = p_op;
            req_addr_d  = p_addr;
            req_valid_d = 1'b1;
            state_d     = ST_ISSUE;
            if (p_trunc) err_count_d = err_inc;
          end
        end
      end
      ST_ISSUE: begin
        if (req_valid_q && req_ready) begin
          req_valid_d = 1'b0;
          state_d     = ST_FETCH;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_valid_q  <= 1'b0;
      req_op_q     <= 4'd0;
      req_addr_q   <= '0;
      line_count_q <= 32'd0;
      err_count_q  <= 16'd0;
      open_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      req_op_q     <= req_op_d;
      req_addr_q   <= req_addr_d;
      line_count_q <= line_count_d;
      err_count_q  <= err_count_d;
      open_err_q   <= open_err_d;
    end
  end

  assign req_valid   = req_valid_q;
  assign req_op      = req_op_q;
  assign req_addr    = req_addr_q;
  assign line_count  = line_count_q;
  assign err_count   = err_count_q;
  assign open_err    = open_err_q;
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_ISSUE);
  assign done        = (state_q == ST_DONE);
  assign line_rd     = (state_q == ST_FETCH) && !p_eof;
  assign log_req     = (state_q == ST_ISSUE) && req_valid_q && req_ready &&
                       (mode >= 32'(VERBOSE_MODE));
  assign log_summary = (state_q != ST_DONE) && (state_d == ST_DONE);

endmodule

// File: tb/tb_trace_request_sequencer.sv
// Scoreboard bench for trace_request_sequencer. Expected requests are
// queued when a trace is launched; a monitor pops and compares on every
// cycle the DUT presents req_valid.
module tb_trace_request_sequencer;

  localparam int MAX_LINE = 128;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [31:0]           file;
  logic [31:0]           mode;
  logic                  start;
  logic                  req_valid;
  logic                  req_ready;
  logic [3:0]            req_op;
  logic [31:0]           req_addr;
  logic                  busy;
  logic                  done;
  logic [31:0]           line_count;
  logic [15:0]           err_count;
  logic                  open_err;
  logic                  line_rd;
  logic [MAX_LINE*8-1:0] line_data;
  logic                  line_eof;
  logic                  log_req;
  logic                  log_summary;

  string trace[$];
  exp_t  exp_q[$];
  int    trace_gen    = 0;
  int    seen_gen     = 0;
  int    line_idx     = 0;
  logic  pending      = 1'b0;
  logic  prev_hs      = 1'b0;
  int    valid_cycles = 0;
  int    cur_mode     = 0;
  int    checks       = 0;
  int    errors       = 0;

  trace_request_sequencer #(
    .ADDR_W       (32),
    .MAX_LINE     (MAX_LINE),
    .VERBOSE_MODE (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .file        (file),
    .mode        (mode),
    .start       (start),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .busy        (busy),
    .done        (done),
    .line_count  (line_count),
    .err_count   (err_count),
    .open_err    (open_err),
    .line_rd     (line_rd),
    .line_data   (line_data),
    .line_eof    (line_eof),
    .log_req     (log_req),
    .log_summary (log_summary)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic refreshLine();
    string s;
    line_data = '0;
    line_eof  = (line_idx >= trace.size());
    if (!line_eof) begin
      s = trace[line_idx];
      for (int k = 0; k < s.len() && k < MAX_LINE; k++) line_data[8*k +: 8] = s.getc(k);
    end
  endtask

  // Trace source: advances past a line the DUT consumed on the last edge.
  initial begin
    refreshLine();
    forever begin
      @(negedge clk);
      pending = line_rd;
      @(posedge clk);
      #1;
      if (seen_gen != trace_gen) begin
        seen_gen = trace_gen;
        line_idx = 0;
      end else if (pending) begin
        line_idx++;
      end
      refreshLine();
    end
  end

  // Monitor: compare presented requests against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) checkOutput("issue_spacing", 64'(req_valid), 64'd0);
        prev_hs = 1'b0;
        if (req_valid) begin
          valid_cycles++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_req: got op=%0d addr=0x%0h expected none",
                     req_op, req_addr);
          end else begin
            checkOutput("req_op", 64'(req_op), 64'(exp_q[0].op));
            checkOutput("req_addr", 64'(req_addr), 64'(exp_q[0].addr));
            if (req_ready) begin
              checkOutput("log_req", 64'(log_req), 64'(cur_mode >= 1));
              e = exp_q.pop_front();
              prev_hs = 1'b1;
              if (log_req) $display("[TB] issue op=%0d addr=0x%0h", req_op, req_addr);
            end
          end
        end
        if (log_summary)
          $display("[TB] trace summary lines=%0d err=%0d", line_count, err_count);
      end
    end
  end

  task automatic resetDut();
    rst_n     = 1'b0;
    start     = 1'b0;
    req_ready = 1'b0;
    file      = 32'd0;
    mode      = 32'd0;
    trace_gen++;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] f, input logic [31:0] m);
    file     = f;
    mode     = m;
    cur_mode = int'(m);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!req_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 64'(req_valid), 64'd1);
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 64'(done), 64'd1);
  endtask

  initial begin
    // Reset state
    trace = {};
    resetDut();
    checkOutput("rst_req_valid", 64'(req_valid), 64'd0);
    checkOutput("rst_req_op", 64'(req_op), 64'd0);
    checkOutput("rst_req_addr", 64'(req_addr), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_line_count", 64'(line_count), 64'd0);
    checkOutput("rst_err_count", 64'(err_count), 64'd0);
    checkOutput("rst_open_err", 64'(open_err), 64'd0);

    // Two requests, ready always high, verbose mode
    trace = {"0 10", "2 408"};
    resetDut();
    exp_q.push_back('{4'd0, 32'h10});
    exp_q.push_back('{4'd2, 32'h408});
    req_ready = 1'b1;
    applyStimulus(32'd3, 32'd1);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    waitDone("t1_done");
    checkOutput("t1_line_count", 64'(line_count), 64'd2);
    checkOutput("t1_err_count", 64'(err_count), 64'd0);
    checkOutput("t1_busy_done", 64'(busy), 64'd0);
    checkOutput("t1_pending", 64'(exp_q.size()), 64'd0);

    // Backpressure: first request held for 5 cycles
    trace = {"0 10", "2 408"};
    resetDut();
    exp_q.push_back('{4'd0, 32'h10});
    exp_q.push_back('{4'd2, 32'h408});
    applyStimulus(32'd3, 32'd0);
    waitValid("t2_valid");
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("t2_hold_valid", 64'(req_valid), 64'd1);
    end
    req_ready = 1'b1;
    waitDone("t2_done");
    checkOutput("t2_line_count", 64'(line_count), 64'd2);
    checkOutput("t2_pending", 64'(exp_q.size()), 64'd0);

    // Illegal op, garbage and blank lines are skipped
    trace = {"7 20", "x", "", "1 FF"};
    resetDut();
    exp_q.push_back('{4'd1, 32'hFF});
    req_ready = 1'b1;
    applyStimulus(32'd3, 32'd0);
    waitDone("t3_done");
    checkOutput("t3_line_count", 64'(line_count), 64'd4);
    checkOutput("t3_err_count", 64'(err_count), 64'd2);
    checkOutput("t3_pending", 64'(exp_q.size()), 64'd0);

    // Open failure
    trace = {"0 10"};
    resetDut();
    req_ready    = 1'b1;
    valid_cycles = 0;
    checkOutput("t4_done_before", 64'(done), 64'd0);
    applyStimulus(32'd0, 32'd0);
    checkOutput("t4_open_err", 64'(open_err), 64'd1);
    checkOutput("t4_done", 64'(done), 64'd1);
    checkOutput("t4_busy", 64'(busy), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t4_no_valid", 64'(valid_cycles), 64'd0);
    checkOutput("t4_line_count", 64'(line_count), 64'd0);

    // Reset during the second of three requests, then resume
    trace = {"1 100", "1 200", "1 300"};
    resetDut();
    exp_q.push_back('{4'd1, 32'h100});
    exp_q.push_back('{4'd1, 32'h200});
    applyStimulus(32'd3, 32'd0);
    waitValid("t5_valid1");
    req_ready = 1'b1;
    @(posedge clk);
    #1 req_ready = 1'b0;
    waitValid("t5_valid2");
    checkOutput("t5_addr2", 64'(req_addr), 64'h200);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_valid", 64'(req_valid), 64'd0);
    checkOutput("t5_rst_addr", 64'(req_addr), 64'd0);
    checkOutput("t5_rst_busy", 64'(busy), 64'd0);
    checkOutput("t5_rst_lines", 64'(line_count), 64'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    exp_q.push_back('{4'd1, 32'h300});
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 req_ready = 1'b1;
    applyStimulus(32'd3, 32'd0);
    waitDone("t5_done");
    checkOutput("t5_line_count", 64'(line_count), 64'd1);
    checkOutput("t5_err_count", 64'(err_count), 64'd0);
    checkOutput("t5_pending", 64'(exp_q.size()), 64'd0);

    // Truncated address, padded whitespace, lowercase hex
    trace = {"2 1FFFFFFFF", "  9   abc  ", "3 0"};
    resetDut();
    exp_q.push_back('{4'd2, 32'hFFFFFFFF});
    exp_q.push_back('{4'd9, 32'hABC});
    exp_q.push_back('{4'd3, 32'h0});
    req_ready = 1'b1;
    applyStimulus(32'd5, 32'd1);
    waitDone("t6_done");
    checkOutput("t6_line_count", 64'(line_count), 64'd3);
    checkOutput("t6_err_count", 64'(err_count), 64'd1);
    checkOutput("t6_pending", 64'(exp_q.size()), 64'd0);

    // Start in DONE is ignored
    applyStimulus(32'd5, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t7_done_hold", 64'(done), 64'd1);
    checkOutput("t7_line_hold", 64'(line_count), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
